serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//   Bit-serial subtract sequencer: owns one 1-bit fullsubtractor cell and drives it
//   LSB-first over WIDTH cycles to compute diff = a - b - bin.
//   Sits beside the ALU as the low-area subtract path; start/done handshake to issue logic.
//   Holds operand and result shift registers, the registered borrow chain and the cycle counter.
// PARAMETERS
//   WIDTH   16               operand/result width in bits (>=2)
//   CNT_W   $clog2(WIDTH)    bit-counter width (derived; do not override)
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; sampled only in IDLE or DONE
//   a         in   WIDTH  minuend; captured on accepted start
//   b         in   WIDTH  subtrahend; captured on accepted start
//   bin       in   1      borrow-in for chaining; captured on accepted start
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse; result valid
//   diff      out  WIDTH  result; held from done until the next accepted start
//   borrow    out  1      final borrow-out (1 = unsigned a < b+bin)
//   zero      out  1      diff == 0
//   overflow  out  1      signed overflow of a - b - bin
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy, done, diff, borrow, zero, overflow = 0;
//     operand regs, borrow reg and counter = 0. Reset mid-RUN aborts; no done is produced.
//   FSM: IDLE -> RUN on start; RUN -> DONE when cnt==WIDTH-1 at the edge;
//     DONE -> RUN if start, else IDLE. RUN ignores start (no queueing, no abort).
//   Accept edge: a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, diff/flags cleared; busy=1 next cycle.
//   Each RUN edge: cell(A=a_sh[0], B=b_sh[0], Bin=brw) -> Sub shifted into diff MSB
//     (diff<={Sub,diff[WIDTH-1:1]}); brw<=Bout; a_sh, b_sh shift right; cnt++.
//   Latency: start at edge k -> WIDTH processing edges k+1..k+WIDTH -> done=1 in the
//     cycle after edge k+WIDTH. Start to done = WIDTH+1 cycles; back-to-back throughput
//     is one op every WIDTH+1 cycles (start held high in DONE re-enters RUN immediately).
//   At the RUN->DONE edge: borrow<=final Bout; zero<=(final diff==0);
//     overflow<=(a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using captured MSBs
//     (operand MSBs saved at accept). Flags and diff remain stable through IDLE.
//   Arithmetic: modulo 2^WIDTH; bin adds one extra LSB borrow; no saturation.
//   done is high only in DONE; busy and done are never high together.
//   a, b, bin are don't-care except on the accept edge.
// TESTING (WIDTH=8 unless noted)
//   reset: rst_n=0 asynchronously mid-RUN (a=0x55,b=0x11) -> all outputs 0 immediately,
//     IDLE; no done pulse; next start works normally.
//   basic: a=0x37,b=0x12,bin=0 -> done 9 cycles after start, diff=0x25, borrow=0,
//     zero=0, overflow=0; busy high exactly 8 cycles.
//   underflow: a=0x00,b=0x01,bin=0 -> diff=0xFF, borrow=1; a=0x05,b=0x05 -> diff=0x00,
//     zero=1, borrow=0.
//   signed ovf and bin: a=0x80,b=0x01 -> diff=0x7F, overflow=1; a=0x10,b=0x0F,bin=1 ->
//     diff=0x00, zero=1, borrow=0.
//   handshake: start pulsed during RUN -> ignored, no extra op; start held through DONE ->
//     second op begins at once, done pulses 9 cycles apart, diff held between pulses.
//   sweep: random a/b/bin, WIDTH=8 and 16, vs reference model a-b-bin -> diff and all
//     flags match.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Latency: purely combinational.
// Backpressure: none; the cell has no handshake.
module serial_sub_fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// Bit-serial subtract sequencer: diff = a - b - bin, LSB first, one bit per cycle.
// Latency: done pulses WIDTH+1 cycles after the start cycle; one op per WIDTH+1 cycles.
// Backpressure: start is only accepted in IDLE or DONE; requests during RUN are dropped.
module serial_sub_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  // Operand sign bits are shifted out early, so keep copies for the overflow flag.
  logic             a_msb;
  logic             b_msb;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] diff_nxt;
  logic             last_bit;
  logic             accept;

  serial_sub_fullsub u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign diff_nxt = {cell_d, diff[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // Sequencer: operand capture, one result bit per RUN cycle, flags on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            state    <= RUN;
            a_sh     <= a;
            b_sh     <= b;
            brw      <= bin;
            cnt      <= '0;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            busy     <= 1'b1;
            diff     <= '0;
            borrow   <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          diff <= diff_nxt;
          brw  <= cell_bout;
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            borrow   <= cell_bout;
            zero     <= (diff_nxt == '0);
            overflow <= (a_msb != b_msb) && (cell_d != a_msb);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start8;
  logic        start16;
  logic [15:0] av;
  logic [15:0] bv;
  logic        binv;

  logic        busy8, done8, borrow8, zero8, ovf8;
  logic [7:0]  diff8;
  logic        busy16, done16, borrow16, zero16, ovf16;
  logic [15:0] diff16;

  int nvec = 0;
  int nerr = 0;
  int both_hi = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(av[7:0]), .b(bv[7:0]), .bin(binv),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8),
    .overflow(ovf8)
  );

  serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(av), .b(bv), .bin(binv),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .zero(zero16),
    .overflow(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if ((busy8 && done8) || (busy16 && done16)) both_hi++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op on the chosen instance and wait (bounded) for its done pulse.
  task automatic run_op(input bit w, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, output logic [15:0] d, output logic br,
                        output logic z, output logic ov, output int lat, output int bc);
    @(posedge clk); #1;
    av = a; bv = b; binv = bi;
    if (w) start16 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    lat = 0;
    bc  = 0;
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
    while (!(w ? done16 : done8) && lat < 60) begin
      @(negedge clk);
      lat++;
      if (w ? busy16 : busy8) bc++;
    end
    d  = w ? diff16 : {8'h00, diff8};
    br = w ? borrow16 : borrow8;
    z  = w ? zero16 : zero8;
    ov = w ? ovf16 : ovf8;
  endtask

  initial begin
    logic [15:0] d;
    logic        br, z, ov;
    int          lat, bc, cyc, dones, t1, t2;
    logic [16:0] full;
    logic [15:0] ra, rb, ed;
    logic        rbin, eo;

    tbl[0] = '{8'h37, 8'h12, 1'b0, 8'h25, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; av = '0; bv = '0; binv = 1'b0;
    #2;
    chk("rst_busy", {31'b0, busy8}, 0);
    chk("rst_done", {31'b0, done8}, 0);
    chk("rst_diff", {24'b0, diff8}, 0);
    chk("rst_flags", {29'b0, borrow8, zero8, ovf8}, 0);
    #20 rst_n = 1'b1;

    // Async reset in the middle of a RUN: outputs drop at once, no done follows.
    @(posedge clk); #1;
    av = 16'h0055; bv = 16'h0011; binv = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy8}, 0);
    chk("midrst_out", {21'b0, diff8, done8, borrow8, zero8, ovf8}, 0);
    dones = 0;
    repeat (3) @(negedge clk) if (done8) dones++;
    rst_n = 1'b1;
    repeat (15) @(negedge clk) if (done8 || busy8) dones++;
    chk("midrst_no_done", dones, 0);

    // Directed table on the 8-bit instance.
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].bin, d, br, z, ov, lat, bc);
      chk($sformatf("v%0d_lat", i), lat, 9);
      chk($sformatf("v%0d_busy", i), bc, 8);
      chk($sformatf("v%0d_diff", i), {16'b0, d}, {24'b0, tbl[i].diff});
      chk($sformatf("v%0d_borrow", i), {31'b0, br}, {31'b0, tbl[i].borrow});
      chk($sformatf("v%0d_zero", i), {31'b0, z}, {31'b0, tbl[i].zero});
      chk($sformatf("v%0d_ovf", i), {31'b0, ov}, {31'b0, tbl[i].ovf});
    end

    // Result and flags stay put through IDLE.
    repeat (5) @(negedge clk);
    chk("idle_hold", {20'b0, diff8, done8, borrow8, zero8, ovf8},
        {20'b0, tbl[7].diff, 1'b0, tbl[7].borrow, tbl[7].zero, tbl[7].ovf});

    // start pulsed during RUN is ignored.
    @(posedge clk); #1;
    av = 16'h0040; bv = 16'h0003; binv = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 av = 16'h00FF; bv = 16'h0000; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("ign_done_seen", {31'b0, done8}, 1);
    chk("ign_diff", {24'b0, diff8}, 32'h3D);
    dones = 0;
    repeat (20) @(negedge clk) if (done8 || busy8) dones++;
    chk("ign_no_extra", dones, 0);

    // start held through DONE: second op starts at once, done pulses 9 cycles apart.
    @(posedge clk); #1;
    av = 16'h0037; bv = 16'h0012; binv = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    av = 16'h0020; bv = 16'h0030;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (done8) begin
        if (t1 < 0) begin
          t1 = cyc;
          chk("b2b_diff1", {24'b0, diff8}, 32'h25);
          @(posedge clk); #1; start8 = 1'b0;
        end else begin
          t2 = cyc;
        end
      end
    end
    chk("b2b_gap", t2 - t1, 9);
    chk("b2b_diff2", {21'b0, diff8, borrow8, zero8, ovf8}, {21'b0, 8'hF0, 3'b100});

    // Random sweep against a - b - bin on both widths.
    for (int i = 0; i < 24; i++) begin
      bit w;
      w    = (i >= 12);
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (!w) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
      if (w) begin
        full = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
        ed   = full[15:0];
        eo   = (ra[15] != rb[15]) && (ed[15] != ra[15]);
      end else begin
        full = {9'b0, ra[7:0]} - {9'b0, rb[7:0]} - {16'b0, rbin};
        full[16] = full[8];
        ed   = {8'h00, full[7:0]};
        eo   = (ra[7] != rb[7]) && (ed[7] != ra[7]);
      end
      run_op(w, ra, rb, rbin, d, br, z, ov, lat, bc);
      chk($sformatf("sw%0d_lat", i), lat, w ? 17 : 9);
      chk($sformatf("sw%0d_diff", i), {16'b0, d}, {16'b0, ed});
      chk($sformatf("sw%0d_flags", i), {29'b0, br, z, ov}, {29'b0, full[16], (ed == 16'h0), eo});
    end

    chk("busy_done_excl", both_hi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
